// File: rtl/prod_ctrl.sv
// Central control FSM for the Fibonacci/Timer producer subsystem: debounces the
// four user buttons, selects the active producer and strobes slow-clock updates.
module prod_ctrl #(
    parameter int DB_COUNT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_f,
    input  logic       start_t,
    input  logic       stop_f_t,
    input  logic       update,
    input  logic [2:0] prog,
    input  logic       buf_full,
    input  logic       buf_empty,
    output logic       en_f,
    output logic       en_t,
    output logic       wr_sel,
    output logic       load_prog,
    output logic [2:0] prog_q,
    output logic [5:0] led
);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        RUN_F  = 6'b000010,
        RUN_T  = 6'b000100,
        HOLD_F = 6'b001000,
        HOLD_T = 6'b010000,
        UPD    = 6'b100000
    } state_t;

    localparam int              CW      = $clog2(DB_COUNT + 2);
    localparam logic [CW-1:0]   CNT_HIT = CW'(DB_COUNT);
    localparam logic [CW-1:0]   CNT_SAT = CW'(DB_COUNT + 1);

    state_t        state;
    state_t        next_state;
    state_t        ret_state;

    logic [3:0]    raw;
    logic [3:0]    press;
    logic [CW-1:0] db_cnt [4];

    logic          start_f_p;
    logic          start_t_p;
    logic          stop_p;
    logic          upd_p;

    assign raw       = {update, stop_f_t, start_t, start_f};
    assign start_f_p = press[0];
    assign start_t_p = press[1];
    assign stop_p    = press[2];
    assign upd_p     = press[3];

    // The counter runs one step past DB_COUNT and parks there, so the press
    // pulse fires only on the single cycle the count equals DB_COUNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: db_cnt is a handful of flops, not a RAM, so it is cleared
            // like any other register; a held button must recount after reset.
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            press <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!raw[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != CNT_SAT) begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
                press[i] <= raw[i] && (db_cnt[i] == CNT_HIT);
            end
        end
    end

    // Priority within every state: stop > update > buf_full > start.
    always_comb begin
        // NOTE: next_state is defaulted before the case so every path assigns
        // it and no latch is inferred.
        next_state = state;
        case (state)
            IDLE: begin
                if (stop_p)         next_state = IDLE;
                else if (upd_p)     next_state = UPD;
                else if (start_f_p) next_state = RUN_F;
                else if (start_t_p) next_state = RUN_T;
            end
            RUN_F: begin
                if (stop_p)         next_state = IDLE;
                else if (upd_p)     next_state = UPD;
                else if (buf_full)  next_state = HOLD_F;
                else if (start_t_p) next_state = RUN_T;
            end
            RUN_T: begin
                if (stop_p)         next_state = IDLE;
                else if (upd_p)     next_state = UPD;
                else if (buf_full)  next_state = HOLD_T;
                else if (start_f_p) next_state = RUN_F;
            end
            HOLD_F: begin
                if (stop_p)         next_state = IDLE;
                else if (upd_p)     next_state = UPD;
                else if (buf_empty) next_state = RUN_F;
            end
            HOLD_T: begin
                if (stop_p)         next_state = IDLE;
                else if (upd_p)     next_state = UPD;
                else if (buf_empty) next_state = RUN_T;
            end
            UPD:     next_state = ret_state;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            ret_state <= IDLE;
            prog_q    <= '0;
            wr_sel    <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == UPD && state != UPD) begin
                ret_state <= state;
                prog_q    <= prog;
            end
            // wr_sel follows the producer of the next state; IDLE/UPD keep it.
            if (next_state == RUN_F || next_state == HOLD_F) begin
                wr_sel <= 1'b0;
            end else if (next_state == RUN_T || next_state == HOLD_T) begin
                wr_sel <= 1'b1;
            end
        end
    end

    assign en_f      = (state == RUN_F);
    assign en_t      = (state == RUN_T);
    assign load_prog = (state == UPD);
    assign led       = state;

endmodule

// File: tb/tb_prod_ctrl.sv
// Directed bench for prod_ctrl with DB_COUNT = 4; each task drives one scenario
// and compares outputs against hand-computed values one time unit after the edge.
module tb_prod_ctrl;

    localparam int DB = 4;

    localparam logic [5:0] L_IDLE   = 6'b000001;
    localparam logic [5:0] L_RUN_F  = 6'b000010;
    localparam logic [5:0] L_RUN_T  = 6'b000100;
    localparam logic [5:0] L_HOLD_F = 6'b001000;
    localparam logic [5:0] L_HOLD_T = 6'b010000;
    localparam logic [5:0] L_UPD    = 6'b100000;

    localparam logic [3:0] B_START_F = 4'b0001;
    localparam logic [3:0] B_START_T = 4'b0010;
    localparam logic [3:0] B_STOP    = 4'b0100;
    localparam logic [3:0] B_UPDATE  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_f, start_t, stop_f_t, update;
    logic [2:0] prog;
    logic       buf_full, buf_empty;
    logic       en_f, en_t, wr_sel, load_prog;
    logic [2:0] prog_q;
    logic [5:0] led;

    int errors = 0;
    int checks = 0;

    prod_ctrl #(.DB_COUNT(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_f   (start_f),
        .start_t   (start_t),
        .stop_f_t  (stop_f_t),
        .update    (update),
        .prog      (prog),
        .buf_full  (buf_full),
        .buf_empty (buf_empty),
        .en_f      (en_f),
        .en_t      (en_t),
        .wr_sel    (wr_sel),
        .load_prog (load_prog),
        .prog_q    (prog_q),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] mask);
        start_f  = mask[0];
        start_t  = mask[1];
        stop_f_t = mask[2];
        update   = mask[3];
    endtask

    // Hold buttons for edges 0..DB (pulse registered at edge DB), release, and
    // take edge DB+1 where the FSM acts on the pulse.
    task automatic press_btns(input logic [3:0] mask);
        set_btns(mask);
        repeat (DB + 1) tick();
        set_btns(4'b0000);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_btns(4'b0000);
        buf_full  = 1'b0;
        buf_empty = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        prog = 3'b000;
        do_reset();
        checks++;
        if ({led, en_f, en_t, wr_sel, load_prog, prog_q} !== {L_IDLE, 4'b0000, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got led=%b en_f=%b en_t=%b wr_sel=%b load=%b prog_q=%b, want led=000001 all others 0",
                     led, en_f, en_t, wr_sel, load_prog, prog_q);
        end
    endtask

    task automatic test_start_latency();
        logic early = 1'b0;
        set_btns(B_START_F);
        for (int k = 0; k <= DB; k++) begin
            tick();
            if (led !== L_IDLE) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL start_too_early: led left IDLE before edge %0d, now led=%b", DB + 1, led);
        end
        tick();
        set_btns(4'b0000);
        checks++;
        if (led !== L_RUN_F || en_f !== 1'b1 || en_t !== 1'b0) begin
            errors++;
            $display("FAIL start_f_edge5: got led=%b en_f=%b en_t=%b, want 000010 1 0", led, en_f, en_t);
        end
        repeat (4) tick();
        checks++;
        if (led !== L_RUN_F || wr_sel !== 1'b0) begin
            errors++;
            $display("FAIL start_f_single: got led=%b wr_sel=%b, want 000010 0", led, wr_sel);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        set_btns(B_START_F);
        repeat (DB - 1) tick();
        set_btns(4'b0000);
        repeat (5) tick();
        checks++;
        if (led !== L_IDLE || en_f !== 1'b0) begin
            errors++;
            $display("FAIL glitch_rejected: got led=%b en_f=%b, want 000001 0", led, en_f);
        end
        buf_full = 1'b1;
        repeat (2) tick();
        buf_full = 1'b0;
        checks++;
        if (led !== L_IDLE) begin
            errors++;
            $display("FAIL idle_buf_full_ignored: got led=%b, want 000001", led);
        end
    endtask

    task automatic test_hold();
        press_btns(B_START_F);
        buf_full = 1'b1;
        tick();
        checks++;
        if (led !== L_HOLD_F || en_f !== 1'b0 || wr_sel !== 1'b0) begin
            errors++;
            $display("FAIL hold_f_enter: got led=%b en_f=%b wr_sel=%b, want 001000 0 0", led, en_f, wr_sel);
        end
        press_btns(B_START_T);
        checks++;
        if (led !== L_HOLD_F) begin
            errors++;
            $display("FAIL hold_start_ignored: got led=%b, want 001000", led);
        end
        buf_full  = 1'b0;
        buf_empty = 1'b1;
        tick();
        buf_empty = 1'b0;
        checks++;
        if (led !== L_RUN_F || en_f !== 1'b1) begin
            errors++;
            $display("FAIL hold_f_resume: got led=%b en_f=%b, want 000010 1", led, en_f);
        end
    endtask

    task automatic test_update();
        press_btns(B_START_T);
        checks++;
        if (led !== L_RUN_T || en_t !== 1'b1 || wr_sel !== 1'b1) begin
            errors++;
            $display("FAIL run_f_to_run_t: got led=%b en_t=%b wr_sel=%b, want 000100 1 1", led, en_t, wr_sel);
        end
        prog = 3'b101;
        press_btns(B_UPDATE);
        prog = 3'b010;
        checks++;
        if (led !== L_UPD || load_prog !== 1'b1 || prog_q !== 3'b101 || en_t !== 1'b0) begin
            errors++;
            $display("FAIL upd_cycle: got led=%b load=%b prog_q=%b en_t=%b, want 100000 1 101 0",
                     led, load_prog, prog_q, en_t);
        end
        tick();
        checks++;
        if (led !== L_RUN_T || load_prog !== 1'b0 || prog_q !== 3'b101 || en_t !== 1'b1) begin
            errors++;
            $display("FAIL upd_return: got led=%b load=%b prog_q=%b en_t=%b, want 000100 0 101 1",
                     led, load_prog, prog_q, en_t);
        end
        buf_full = 1'b1;
        tick();
        buf_full = 1'b0;
        press_btns(B_UPDATE);
        tick();
        checks++;
        if (led !== L_HOLD_T || prog_q !== 3'b010 || wr_sel !== 1'b1) begin
            errors++;
            $display("FAIL upd_from_hold_t: got led=%b prog_q=%b wr_sel=%b, want 010000 010 1", led, prog_q, wr_sel);
        end
        buf_empty = 1'b1;
        tick();
        buf_empty = 1'b0;
        checks++;
        if (led !== L_RUN_T) begin
            errors++;
            $display("FAIL hold_t_resume: got led=%b, want 000100", led);
        end
    endtask

    task automatic test_stop_priority();
        press_btns(B_STOP | B_START_F);
        checks++;
        if (led !== L_IDLE || en_f !== 1'b0 || en_t !== 1'b0 || wr_sel !== 1'b1) begin
            errors++;
            $display("FAIL stop_beats_start: got led=%b en_f=%b en_t=%b wr_sel=%b, want 000001 0 0 1",
                     led, en_f, en_t, wr_sel);
        end
        press_btns(B_START_T);
        checks++;
        if (led !== L_RUN_T || wr_sel !== 1'b1 || en_t !== 1'b1) begin
            errors++;
            $display("FAIL restart_t: got led=%b wr_sel=%b en_t=%b, want 000100 1 1", led, wr_sel, en_t);
        end
        press_btns(B_STOP);
        press_btns(B_START_F | B_START_T);
        checks++;
        if (led !== L_RUN_F || wr_sel !== 1'b0) begin
            errors++;
            $display("FAIL both_start_f_wins: got led=%b wr_sel=%b, want 000010 0", led, wr_sel);
        end
    endtask

    task automatic test_reset_in_upd();
        prog = 3'b011;
        press_btns(B_UPDATE);
        checks++;
        if (led !== L_UPD || prog_q !== 3'b011) begin
            errors++;
            $display("FAIL upd_before_rst: got led=%b prog_q=%b, want 100000 011", led, prog_q);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (led !== L_IDLE || load_prog !== 1'b0 || prog_q !== 3'b000 || wr_sel !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_upd: got led=%b load=%b prog_q=%b wr_sel=%b, want 000001 0 000 0",
                     led, load_prog, prog_q, wr_sel);
        end
    endtask

    task automatic test_held_through_reset();
        logic early = 1'b0;
        rst = 1'b1;
        set_btns(B_START_F);
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k <= DB; k++) begin
            tick();
            if (led !== L_IDLE) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL held_rst_early: led left IDLE before full recount, now led=%b", led);
        end
        tick();
        set_btns(4'b0000);
        checks++;
        if (led !== L_RUN_F) begin
            errors++;
            $display("FAIL held_rst_recount: got led=%b, want 000010", led);
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_glitch();
        test_hold();
        test_update();
        test_stop_priority();
        test_reset_in_upd();
        test_held_through_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prod_ctrl.md
Name: prod_ctrl

Overview:
- Central control FSM for the Fibonacci/Timer producer subsystem.
- Debounces the four user buttons and decides which producer (Fibonacci or Timer) is enabled.
- Pauses production while the shared output buffer is full, and issues slow-clock reprogramming commands.
- Drives the one-hot state LEDs; sits between the board buttons and the producers, buffer and slow-clock divider.

Parameters:
- DB_COUNT, 500, consecutive clk cycles a raw button must be high before its press is accepted; minimum 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- start_f  in  1  raw button: start/resume Fibonacci.
- start_t  in  1  raw button: start/resume Timer.
- stop_f_t  in  1  raw button: stop both producers.
- update  in  1  raw button: reprogram slow clock.
- prog  in  3  requested slow-clock frequency code.
- buf_full  in  1  shared buffer full.
- buf_empty  in  1  shared buffer empty.
- en_f  out  1  Fibonacci producer enable.
- en_t  out  1  Timer producer enable.
- wr_sel  out  1  buffer write source: 0 = Fibonacci, 1 = Timer.
- load_prog  out  1  one-cycle strobe to the slow-clock divider.
- prog_q  out  3  latched frequency code, valid when load_prog is high and held afterwards.
- led  out  6  one-hot state indicator.

Behaviour:
- Debounce, per button, independent:
  - A counter increments while the raw input is high and clears to 0 when it is low.
  - When the counter reaches DB_COUNT, an internal press pulse is registered for exactly 1 cycle; the counter then saturates.
  - No further pulse until the button goes low again, so one press gives one pulse.
  - The FSM acts on a pulse at the next clock edge: raw high at edge 0 → pulse high after edge DB_COUNT → state changes at edge DB_COUNT+1.
- States and led encoding:
  - IDLE = 000001
  - RUN_F = 000010
  - RUN_T = 000100
  - HOLD_F = 001000
  - HOLD_T = 010000
  - UPD = 100000
- Transitions are evaluated each cycle with priority stop > update > buf_full > start:
  - IDLE: start_f → RUN_F; start_t → RUN_T; if both pulse in the same cycle, RUN_F wins.
  - RUN_F: stop → IDLE; update → UPD; buf_full → HOLD_F; start_t → RUN_T.
  - RUN_T: stop → IDLE; update → UPD; buf_full → HOLD_T; start_f → RUN_F.
  - HOLD_F / HOLD_T: stop → IDLE; update → UPD; buf_empty → RUN_F / RUN_T respectively. Start pulses are ignored in these states.
  - Update pulse in IDLE → UPD.
  - UPD: lasts exactly 1 cycle; on the next edge returns to the state held in ret_state.
- ret_state and prog_q capture:
  - On entering UPD, ret_state captures the current state, and prog_q captures prog.
  - If the captured state was HOLD_x and buf_full has since dropped, normal HOLD rules apply after the return.
- Outputs (all registered/state-decoded, glitch-free):
  - en_f = (state == RUN_F); en_t = (state == RUN_T).
  - wr_sel = 1 in RUN_T/HOLD_T; 0 in RUN_F/HOLD_F; holds its last value in IDLE and UPD.
  - load_prog = (state == UPD).
- Stop:
  - Only deasserts enables; producer contents are not cleared.
  - A subsequent start resumes from the last value; reset of the producers comes only from rst.
- Stray inputs:
  - buf_full in IDLE or UPD is ignored.
  - buf_empty outside HOLD states is ignored.
- Reset:
  - Reset values: state = IDLE, led = 000001, en_f = 0, en_t = 0, wr_sel = 0, load_prog = 0, prog_q = 000, ret_state = IDLE, all debounce counters = 0, pulses = 0.
  - rst asserted mid-operation (including during UPD) forces these values at the next edge. A button held through reset must complete a full DB_COUNT count after rst drops.

Test Plan (DB_COUNT = 4):
1. Reset, then start_f held 6 cycles → led 000010 and en_f = 1 exactly 5 edges after the press begins; one press → exactly one transition.
2. start_f glitch high 3 cycles, then low → no pulse, led stays 000001, en_f = 0.
3. RUN_F, buf_full = 1 → next edge led 001000, en_f = 0; then buf_full = 0, buf_empty = 1 → next edge led 000010, en_f = 1.
4. RUN_T with prog = 101, update press → one cycle with led 100000, load_prog = 1, prog_q = 101, en_t = 0; next edge led 000100.
5. RUN_T, stop_f_t and start_f pulses in the same cycle → led 000001, en_f = en_t = 0; then start_t → RUN_T, wr_sel = 1.
6. rst asserted during UPD → next edge led 000001, load_prog = 0, prog_q = 000.
